// File: rtl/zchk_pkg.sv
// Shared types and widths for the zero-check arbiter slice.
// Optional perf counters are enabled with ZCHK_PERF_EN.
package zchk_pkg;

    localparam int ZCHK_DATA_W = 64;
    localparam int ZCHK_PERF_W = 16;

    typedef enum logic {
        ZCHK_SRC_FLAG = 1'b0,
        ZCHK_SRC_BR   = 1'b1
    } zchk_src_e;

endpackage

// File: rtl/zero_detect_64.sv
// Combinational 64-bit all-zero detector.
// Three levels of 4-input gates: 64 -> 16 -> 4 -> 1.
module zero_detect_64
    import zchk_pkg::*;
(
    input  logic [ZCHK_DATA_W-1:0] data,
    output logic                   zero
);

    logic [15:0] lvl1;
    logic [3:0]  lvl2;

    for (genvar i = 0; i < 16; i++) begin : g_lvl1
        assign lvl1[i] = |data[4*i +: 4];
    end

    for (genvar j = 0; j < 4; j++) begin : g_lvl2
        assign lvl2[j] = |lvl1[4*j +: 4];
    end

    assign zero = ~|lvl2;

endmodule

// File: rtl/zero_check_arbiter.sv
// Two-requester arbiter sharing one 64-bit zero detector, registered response.
// Define ZCHK_PERF_EN to add saturating grant/stall perf counters.
module zero_check_arbiter
    import zchk_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ZCHK_DATA_W-1:0] req0_data,
    input  logic [TAG_W-1:0]       req0_tag,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ZCHK_DATA_W-1:0] req1_data,
    input  logic [TAG_W-1:0]       req1_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_zero,
    output logic                   rsp_src,
    output logic [TAG_W-1:0]       rsp_tag
`ifdef ZCHK_PERF_EN
    ,
    output logic [ZCHK_PERF_W-1:0] perf_grant0,
    output logic [ZCHK_PERF_W-1:0] perf_grant1,
    output logic [ZCHK_PERF_W-1:0] perf_stall
`endif
);

    zchk_src_e              gnt;
    logic                   rr_ptr;
    logic                   can_accept;
    logic                   xfer0;
    logic                   xfer1;
    logic                   xfer;
    logic                   contended;
    logic                   det_zero;
    logic [ZCHK_DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]       sel_tag;

    always_comb begin
        gnt = ZCHK_SRC_FLAG;
        if (req0_valid && req1_valid)
            gnt = (PRIO_MODE == 1) ? ZCHK_SRC_FLAG : zchk_src_e'(rr_ptr);
        else if (req1_valid)
            gnt = ZCHK_SRC_BR;
    end

    // Readies are gated by reset so nothing is offered while held in reset.
    assign can_accept = !rsp_valid || rsp_ready;
    assign req0_ready = reset_n && can_accept && (gnt == ZCHK_SRC_FLAG);
    assign req1_ready = reset_n && can_accept && (gnt == ZCHK_SRC_BR);
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign xfer       = xfer0 || xfer1;
    assign contended  = req0_valid && req1_valid;

    assign sel_data = (gnt == ZCHK_SRC_BR) ? req1_data : req0_data;
    assign sel_tag  = (gnt == ZCHK_SRC_BR) ? req1_tag  : req0_tag;

    zero_detect_64 u_zero_detect (
        .data (sel_data),
        .zero (det_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_src   <= 1'b0;
            rsp_tag   <= '0;
            rr_ptr    <= 1'b0;
        end else begin
            if (xfer) begin
                rsp_valid <= 1'b1;
                rsp_zero  <= det_zero;
                rsp_src   <= gnt;
                rsp_tag   <= sel_tag;
                if (contended)
                    rr_ptr <= (gnt == ZCHK_SRC_FLAG);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ZCHK_PERF_EN
    logic stall;

    assign stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (xfer0 && perf_grant0 != '1)
                perf_grant0 <= perf_grant0 + ZCHK_PERF_W'(1);
            if (xfer1 && perf_grant1 != '1)
                perf_grant1 <= perf_grant1 + ZCHK_PERF_W'(1);
            if (stall && perf_stall != '1)
                perf_stall <= perf_stall + ZCHK_PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_zero_check_arbiter.sv
// Bench for zero_check_arbiter: round-robin instance plus fixed-priority instance.
// Perf counter scenario runs only when ZCHK_PERF_EN is defined.
module tb_zero_check_arbiter;
    import zchk_pkg::*;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req1_valid = 1'b0;
    logic             rsp_ready = 1'b0;
    logic [63:0]      req0_data = '0;
    logic [63:0]      req1_data = '0;
    logic [TAG_W-1:0] req0_tag = '0;
    logic [TAG_W-1:0] req1_tag = '0;

    logic             a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_zero, a_rsp_src;
    logic [TAG_W-1:0] a_rsp_tag;
    logic             b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_zero, b_rsp_src;
    logic [TAG_W-1:0] b_rsp_tag;
`ifdef ZCHK_PERF_EN
    logic [15:0] a_pg0, a_pg1, a_pst, b_pg0, b_pg1, b_pst;
`endif

    always #5 clk = ~clk;

    zero_check_arbiter #(.TAG_W(TAG_W), .PRIO_MODE(0)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_zero(a_rsp_zero), .rsp_src(a_rsp_src), .rsp_tag(a_rsp_tag)
`ifdef ZCHK_PERF_EN
        , .perf_grant0(a_pg0), .perf_grant1(a_pg1), .perf_stall(a_pst)
`endif
    );

    zero_check_arbiter #(.TAG_W(TAG_W), .PRIO_MODE(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_zero(b_rsp_zero), .rsp_src(b_rsp_src), .rsp_tag(b_rsp_tag)
`ifdef ZCHK_PERF_EN
        , .perf_grant0(b_pg0), .perf_grant1(b_pg1), .perf_stall(b_pst)
`endif
    );

    typedef struct packed {
        logic             zero;
        logic             src;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic m_rv, m_rr;

    // Reference model of the round-robin instance, stepped on each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb.delete();
            m_rv <= 1'b0;
            m_rr <= 1'b0;
        end else begin
            logic can, g, x;
            exp_t e;
            can = !m_rv || rsp_ready;
            g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
            x   = can && (g ? req1_valid : req0_valid);
            if (m_rv && rsp_ready && sb.size() > 0)
                void'(sb.pop_front());
            if (x) begin
                e.zero = g ? (req1_data == 64'd0) : (req0_data == 64'd0);
                e.src  = g;
                e.tag  = g ? req1_tag : req0_tag;
                sb.push_back(e);
                if (req0_valid && req1_valid)
                    m_rr <= ~g;
            end
            m_rv <= x || (m_rv && !rsp_ready);
        end
    end

    // Scoreboard monitor: compare the held response against the queue head.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_chk++;
            if (a_rsp_valid !== m_rv) begin
                n_fail++;
                $display("FAIL sb_valid: got %b want %b at %0t", a_rsp_valid, m_rv, $time);
            end
            if (m_rv) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got response, want none at %0t", $time);
                end else if ({a_rsp_zero, a_rsp_src, a_rsp_tag} !== sb[0]) begin
                    n_fail++;
                    $display("FAIL sb_rsp: got %h want %h at %0t",
                             {a_rsp_zero, a_rsp_src, a_rsp_tag}, sb[0], $time);
                end
            end
        end
    end

    // Requesters must keep valid/data/tag stable until accepted.
    logic             p0_wait, p1_wait;
    logic [63:0]      p0_d, p1_d;
    logic [TAG_W-1:0] p0_t, p1_t;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_wait <= 1'b0;
            p1_wait <= 1'b0;
        end else begin
            if (p0_wait)
                assert (req0_valid && req0_data == p0_d && req0_tag == p0_t)
                else $error("FAIL req0_hold: valid/data/tag dropped before ready");
            if (p1_wait)
                assert (req1_valid && req1_data == p1_d && req1_tag == p1_t)
                else $error("FAIL req1_hold: valid/data/tag dropped before ready");
            p0_wait <= req0_valid && !a_req0_ready;
            p1_wait <= req1_valid && !a_req1_ready;
            p0_d <= req0_data;
            p0_t <= req0_tag;
            p1_d <= req1_data;
            p1_t <= req1_tag;
        end
    end

    task automatic test_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 64'h5;
        req1_data  = 64'h0;
        req0_tag   = 4'd1;
        req1_tag   = 4'd2;
        rsp_ready  = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %b want 0",
                     {a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag});
        end
        n_chk++;
        if ({a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000",
                     {a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready});
        end
        req1_valid = 1'b0;
        reset_n    = 1'b1;
        #1;
        n_chk++;
        if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 10", {a_req0_ready, a_req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1;
        req0_data  = 64'h0;
        req0_tag   = 4'd3;
        @(negedge clk);
        req0_valid = 1'b0;
        n_chk++;
        if ({a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag} !== {3'b110, 4'd3}) begin
            n_fail++;
            $display("FAIL single_req0: got %b want 1103",
                     {a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag});
        end
        req1_valid = 1'b1;
        req1_data  = 64'h8000_0000_0000_0000;
        req1_tag   = 4'd9;
        @(negedge clk);
        req1_valid = 1'b0;
        n_chk++;
        if ({a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag} !== {3'b101, 4'd9}) begin
            n_fail++;
            $display("FAIL single_req1: got %b want 101 9",
                     {a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag});
        end
        @(negedge clk);
        n_chk++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got %b want 0", a_rsp_valid);
        end
    endtask

    task automatic test_contention();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 64'h0;
        req1_data  = 64'h1;
        req0_tag   = 4'd4;
        req1_tag   = 4'd5;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic want1;
            want1 = (i % 2) == 1;
            #1;
            n_chk++;
            if ({a_req0_ready, a_req1_ready} !== {~want1, want1}) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b want %b", i,
                         {a_req0_ready, a_req1_ready}, {~want1, want1});
            end
            @(negedge clk);
            n_chk++;
            if (a_rsp_valid !== 1'b1 || a_rsp_src !== want1) begin
                n_fail++;
                $display("FAIL rr_src[%0d]: got v=%b src=%b want v=1 src=%b",
                         i, a_rsp_valid, a_rsp_src, want1);
            end
        end
        req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        req1_valid = 1'b1;
        req1_data  = 64'h0;
        req1_tag   = 4'd7;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_data = 64'hFF;
        req1_tag  = 4'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({a_req1_ready, a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag}
                !== {4'b0111, 4'd7}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %b want 0111 0111", i,
                         {a_req1_ready, a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_chk++;
        if (a_req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reaccept: got ready %b want 1", a_req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        n_chk++;
        if ({a_rsp_valid, a_rsp_zero, a_rsp_tag} !== {2'b10, 4'd2}) begin
            n_fail++;
            $display("FAIL bp_reload: got %b want 10 0010",
                     {a_rsp_valid, a_rsp_zero, a_rsp_tag});
        end
        @(negedge clk);
        n_chk++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %b want 0", a_rsp_valid);
        end
    endtask

    task automatic test_fixed_prio();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 64'h10;
        req1_data  = 64'h0;
        req0_tag   = 4'd8;
        req1_tag   = 4'd9;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if ({b_req0_ready, b_req1_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL fp_ready[%0d]: got %b want 10", i,
                         {b_req0_ready, b_req1_ready});
            end
            @(negedge clk);
            n_chk++;
            if ({b_rsp_valid, b_rsp_zero, b_rsp_src, b_rsp_tag} !== {3'b100, 4'd8}) begin
                n_fail++;
                $display("FAIL fp_rsp[%0d]: got %b want 100 1000", i,
                         {b_rsp_valid, b_rsp_zero, b_rsp_src, b_rsp_tag});
            end
        end
        req0_valid = 1'b0;
        #1;
        n_chk++;
        if (b_req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fp_alone: got ready %b want 1", b_req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_midop_reset();
        req0_valid = 1'b1;
        req0_data  = 64'h0;
        req0_tag   = 4'd6;
        rsp_ready  = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        #2;
        n_chk++;
        if (a_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got rsp_valid %b want 1", a_rsp_valid);
        end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag} !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0",
                     {a_rsp_valid, a_rsp_zero, a_rsp_src, a_rsp_tag});
        end
`ifdef ZCHK_PERF_EN
        n_chk++;
        if ({a_pg0, a_pg1, a_pst} !== 48'd0) begin
            n_fail++;
            $display("FAIL mid_perf: got %h %h %h want 0", a_pg0, a_pg1, a_pst);
        end
`endif
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_noreplay: got %b want 0", a_rsp_valid);
        end
    endtask

`ifdef ZCHK_PERF_EN
    task automatic test_perf();
        req0_valid = 1'b1;
        req0_data  = 64'h3;
        req0_tag   = 4'd1;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (a_pg0 !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_count: got %0d want 3", a_pg0);
        end
        repeat (70000 - 3) @(negedge clk);
        req0_valid = 1'b0;
        n_chk++;
        if ({a_pg0, a_pg1, a_pst} !== {16'hFFFF, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL perf_sat: got %h %h %h want ffff 0000 0000",
                     a_pg0, a_pg1, a_pst);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fixed_prio();
        test_midop_reset();
`ifdef ZCHK_PERF_EN
        test_perf();
`endif
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
